// File: rtl/spi_bridge_pkg.sv
// Shared types and command-word layout for the SPI register bridge.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Command bit positions counted from the MSB (1 = top bit).
    localparam int CMD_WR_OFS   = 1;
    localparam int CMD_INCR_OFS = 2;

    // Command word is address + two flag bits, rounded up to whole bytes.
    function automatic int cmd_width(input int addr_w);
        return 8 * ((addr_w + 2 + 7) / 8);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one raw pad input with rise/fall detect.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            q     <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            q     <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~q;
    assign fall = ~sync & q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that decodes a command word and drives a simple register port,
// with burst auto-increment and read prefetch.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              txn_done
);
    localparam int CMD_W = cmd_width(ADDR_W);
    localparam int CNT_W = $clog2(CMD_W > DATA_W ? CMD_W : DATA_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .sync(cs_s), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi_clk),
        .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    state_e             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CMD_W-2:0]   cmd_sh;
    logic [DATA_W-2:0]  rx_sh;
    logic [DATA_W-1:0]  tx_sh;
    logic [CMD_W-1:0]   cmd_word;
    logic               cmd_wr, cmd_incr, word_done, rd_cap;

    assign cmd_word = {cmd_sh, mosi_s};
    assign busy     = (state != ST_IDLE);

    // Ignored command bits and unused edge/level outputs are sunk here.
    logic unused_sig;
    assign unused_sig = &{1'b0, cs_rise, sclk_s, mosi_rise, mosi_fall, cmd_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            cmd_sh    <= '0;
            rx_sh     <= '0;
            cmd_wr    <= 1'b0;
            cmd_incr  <= 1'b0;
            word_done <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            txn_done  <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            txn_done <= 1'b0;
            // Write-burst increment lands the cycle after the strobe.
            if (reg_we && cmd_incr)
                reg_addr <= reg_addr + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_CMD;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end
                end
                default: begin
                    // cs_n high aborts the frame and beats any same-cycle sclk rise.
                    if (cs_s) begin
                        state    <= ST_IDLE;
                        txn_done <= word_done;
                    end else if (sclk_rise) begin
                        if (state == ST_CMD) begin
                            cmd_sh <= cmd_word[CMD_W-2:0];
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt  <= '0;
                                state    <= ST_DATA;
                                cmd_wr   <= cmd_word[CMD_W-CMD_WR_OFS];
                                cmd_incr <= cmd_word[CMD_W-CMD_INCR_OFS];
                                reg_addr <= cmd_word[ADDR_W-1:0];
                                reg_re   <= ~cmd_word[CMD_W-CMD_WR_OFS];
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            rx_sh <= {rx_sh[DATA_W-3:0], mosi_s};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt   <= '0;
                                word_done <= 1'b1;
                                if (cmd_wr) begin
                                    reg_wdata <= {rx_sh, mosi_s};
                                    reg_we    <= 1'b1;
                                end else begin
                                    reg_re <= 1'b1;
                                    if (cmd_incr)
                                        reg_addr <= reg_addr + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // TX path: load on the cycle after reg_re; the first fall of each word keeps
    // the MSB in place since the master samples it on the following rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cap   <= 1'b0;
            tx_sh    <= '0;
            spi_miso <= 1'b0;
        end else begin
            rd_cap <= reg_re;
            if (state == ST_IDLE) begin
                tx_sh    <= '0;
                spi_miso <= 1'b0;
            end else if (rd_cap) begin
                tx_sh    <= reg_rdata;
                spi_miso <= reg_rdata[DATA_W-1];
            end else if (sclk_fall && state == ST_DATA && bit_cnt != '0) begin
                tx_sh    <= tx_sh << 1;
                spi_miso <= tx_sh[DATA_W-2];
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench: an 8-bit-data and a 16-bit-data bridge driven by a bit-banged SPI master.
module tb_spi_reg_bridge;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs8 = 1'b1, cs16 = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic sel16 = 1'b0;

    logic        miso8, we8, re8, busy8, txn8;
    logic [3:0]  addr8;
    logic [7:0]  wdata8, rdata8;
    logic        miso16, we16, re16, busy16, txn16;
    logic [3:0]  addr16;
    logic [15:0] wdata16, rdata16;
    logic        miso_m;

    logic [7:0]  mem8  [16];
    logic [15:0] mem16 [16];

    assign rdata8  = mem8[addr8];
    assign rdata16 = mem16[addr16];
    assign miso_m  = sel16 ? miso16 : miso8;

    always #5 clk = ~clk;

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(cs8), .spi_clk(sclk), .spi_mosi(mosi),
        .spi_miso(miso8), .reg_addr(addr8), .reg_wdata(wdata8), .reg_we(we8),
        .reg_re(re8), .reg_rdata(rdata8), .busy(busy8), .txn_done(txn8));

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(cs16), .spi_clk(sclk), .spi_mosi(mosi),
        .spi_miso(miso16), .reg_addr(addr16), .reg_wdata(wdata16), .reg_we(we16),
        .reg_re(re16), .reg_rdata(rdata16), .busy(busy16), .txn_done(txn16));

    int n_chk = 0, n_pass = 0;
    int txn8_cnt = 0, txn16_cnt = 0;

    logic [11:0] exp_wr8 [$];   // {addr, data}
    logic [3:0]  exp_re8 [$];
    logic [3:0]  exp_re16 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bad(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: unexpected strobe, addr %0h", name, act);
    endtask

    // Monitor: pop expectations whenever a strobe appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we8) begin
                if (exp_wr8.size() == 0) bad("we8", {28'd0, addr8});
                else chk("we8 addr/data", {20'd0, addr8, wdata8}, {20'd0, exp_wr8.pop_front()});
            end
            if (re8) begin
                if (exp_re8.size() == 0) bad("re8", {28'd0, addr8});
                else chk("re8 addr", {28'd0, addr8}, {28'd0, exp_re8.pop_front()});
            end
            if (we16) bad("we16", {28'd0, addr16});
            if (re16) begin
                if (exp_re16.size() == 0) bad("re16", {28'd0, addr16});
                else chk("re16 addr", {28'd0, addr16}, {28'd0, exp_re16.pop_front()});
            end
            if (txn8)  txn8_cnt++;
            if (txn16) txn16_cnt++;
        end
    end

    task automatic xfer(input int n, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx[i] = miso_m;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start(input logic s16);
        sel16 = s16;
        if (s16) cs16 = 1'b0; else cs8 = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        cs8 = 1'b1; cs16 = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " addr8"},  {28'd0, addr8}, 32'd0);
        chk({tag, " wdata8"}, {24'd0, wdata8}, 32'd0);
        chk({tag, " strobes8"}, {29'd0, we8, re8, txn8}, 32'd0);
        chk({tag, " busy/miso8"}, {30'd0, busy8, miso8}, 32'd0);
        chk({tag, " dut16 outs"}, {addr16, wdata16, 7'd0, we16, re16, txn16, busy16, miso16}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        for (int i = 0; i < 16; i++) begin
            mem8[i]  = 8'h00;
            mem16[i] = 16'h0000;
        end
        mem8[3]  = 8'h5C;
        mem16[2] = 16'h1234;
        mem16[3] = 16'hBEEF;
        mem16[4] = 16'h0F0F;

        #1;
        chk_reset_outputs("reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single write: cmd 0x85, data 0xA5; MISO must stay low in a write frame.
        exp_wr8.push_back({4'd5, 8'hA5});
        frame_start(1'b0);
        xfer(8, 32'h85, rx);
        xfer(8, 32'hA5, rx);
        chk("write frame miso", rx, 32'h0);
        frame_end();
        chk("txn8 after single write", txn8_cnt, 1);

        // Burst write with increment, wrapping 15 -> 0.
        exp_wr8.push_back({4'd14, 8'h11});
        exp_wr8.push_back({4'd15, 8'h22});
        exp_wr8.push_back({4'd0,  8'h33});
        frame_start(1'b0);
        xfer(8, 32'hCE, rx);
        xfer(8, 32'h11, rx);
        xfer(8, 32'h22, rx);
        xfer(8, 32'h33, rx);
        frame_end();
        chk("txn8 after burst write", txn8_cnt, 2);
        chk("addr8 after wrap", {28'd0, addr8}, 32'd1);

        // Single read of addr 3, plus the prefetch re-read of the same address.
        exp_re8.push_back(4'd3);
        exp_re8.push_back(4'd3);
        frame_start(1'b0);
        xfer(8, 32'h03, rx);
        xfer(8, 32'h00, rx);
        chk("read8 miso word", rx, 32'h5C);
        frame_end();
        chk("txn8 after read", txn8_cnt, 3);

        // Burst read, 16-bit data, incr from addr 2: reads 2, 3 and prefetch 4.
        exp_re16.push_back(4'd2);
        exp_re16.push_back(4'd3);
        exp_re16.push_back(4'd4);
        frame_start(1'b1);
        xfer(8, 32'h42, rx);
        xfer(16, 32'h0, rx);
        chk("read16 word0", rx, 32'h1234);
        xfer(16, 32'h0, rx);
        chk("read16 word1", rx, 32'hBEEF);
        frame_end();
        chk("txn16 after burst read", txn16_cnt, 1);

        // Abort after 5 data bits: no strobe, no txn_done, back to idle.
        frame_start(1'b0);
        xfer(8, 32'h85, rx);
        xfer(5, 32'h1F, rx);
        chk("busy8 mid-frame", {31'd0, busy8}, 32'd1);
        frame_end();
        chk("txn8 after abort", txn8_cnt, 3);
        chk("busy8 after abort", {31'd0, busy8}, 32'd0);

        // Reset mid burst write, then a clean frame.
        exp_wr8.push_back({4'd8, 8'h11});
        frame_start(1'b0);
        xfer(8, 32'hC8, rx);
        xfer(8, 32'h11, rx);
        xfer(3, 32'h5, rx);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe reset");
        cs8 = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("txn8 after reset", txn8_cnt, 3);
        exp_wr8.push_back({4'd1, 8'h7E});
        frame_start(1'b0);
        xfer(8, 32'h81, rx);
        xfer(8, 32'h7E, rx);
        frame_end();
        chk("txn8 after post-reset write", txn8_cnt, 4);

        chk("wr8 pending", exp_wr8.size(), 0);
        chk("re8 pending", exp_re8.size(), 0);
        chk("re16 pending", exp_re16.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Parametrised SPI-slave to register-bus bridge for peripheral test harnesses. It takes raw SPI pins from the pad ring, synchronises them, decodes a command word, and drives a simple register port (address, write data, write strobe, read strobe, read data) into the peripheral under test. It generalises the fixed 4-bit-address/8-bit-data SPI register access with parametrised widths, burst auto-increment, read prefetch, and a transaction-done pulse.

## Interface
Parameters:
- ADDR_W, 4, register address width (1..14)
- DATA_W, 8, register data width (8, 16 or 32)
- SYNC_STAGES, 2, synchroniser depth on cs_n/sclk/mosi (≥2)

Derived: CMD_W = 8·ceil((ADDR_W+2)/8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_cs_n  in  1  chip select, raw pad
- spi_clk  in  1  SPI clock, raw pad, mode 0
- spi_mosi  in  1  serial data in, raw pad
- spi_miso  out  1  serial data out, registered
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  DATA_W  write data, valid with reg_we
- reg_we  out  1  write strobe, one-cycle pulse
- reg_re  out  1  read strobe, one-cycle pulse
- reg_rdata  in  DATA_W  read data, sampled cycle after reg_re
- busy  out  1  high while not in IDLE
- txn_done  out  1  one-cycle pulse at cs_n deassert if ≥1 full data word completed

## Operation
- Reset values: spi_miso=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, txn_done=0; synchroniser flops reset high for cs_n, low for sclk/mosi.
- Edge detect on synchronised sclk vs one-cycle-delayed copy: rise = s & ~q, fall = ~s & q.
- Frame, MSB first: command word CMD_W bits: bit CMD_W-1 = write(1)/read(0); bit CMD_W-2 = incr; bits ADDR_W-1:0 = address; other bits ignored. Then any number of DATA_W-bit data words.
- FSM: IDLE → CMD on synchronised cs_n fall. CMD → DATA on rise of bit CMD_W-1 (bit counter wraps to 0). DATA → DATA per word. Any state → IDLE on synchronised cs_n high (abort); partial words discarded, no strobes.
- Write: on rise of last bit of a data word, reg_wdata ← assembled word, reg_we pulses with current reg_addr; if incr, reg_addr increments after the strobe, wrapping modulo 2^ADDR_W.
- Read: reg_re pulses on rise of last command bit and on rise of last bit of each data word (prefetch). With incr, address increments after each data word; without, same address re-read. reg_rdata captured next cycle into TX shift register; spi_miso ← MSB on that cycle, then shifts on each fall.
- Prefetched read beyond last word at cs_n rise is harmless; peripherals must tolerate extra reg_re.
- In write frames spi_miso holds 0.

## Timing
- Pad-to-detect latency: SYNC_STAGES+1 clk (+1 sampling uncertainty).
- reg_we / reg_re: cycle after detected rise of triggering bit.
- reg_rdata capture: exactly 1 cycle after reg_re; spi_miso valid 2 cycles after reg_re.
- Constraint: each spi_clk phase ≥ SYNC_STAGES+4 clk cycles (MISO valid before next sclk rise); violating it is unsupported.
- txn_done: cycle after synchronised cs_n rise detected.
- Simultaneous cs_n rise and sclk rise in same cycle: cs_n wins, bit dropped.
- rst_n low mid-frame: all outputs to reset values immediately; frame resumes only at next cs_n fall.

## Structure
- Package spi_bridge_pkg: FSM state enum (IDLE, CMD, DATA), CMD_W derivation function, command bit-position constants.
- One sub-module: spi_sync_edge (SYNC_STAGES synchroniser + rise/fall detect), instanced per SPI input.
- Bit counter width $clog2(max(CMD_W, DATA_W)).

## Test plan
- Single write, ADDR_W=4, DATA_W=8: cmd 0x85, data 0xA5 → one reg_we, reg_addr=5, reg_wdata=0xA5; txn_done once.
- Burst write incr: cmd 0xCE, data 0x11,0x22,0x33 → reg_we at addr 14, 15, 0 (wrap) with 0x11, 0x22, 0x33.
- Single read: cmd 0x03, peripheral returns 0x5C → reg_re at addr 3, MISO shifts 0x5C MSB first.
- Burst read DATA_W=16 incr from addr 2, returns 0x1234, 0xBEEF → both words on MISO, reg_re count 3 (incl. prefetch).
- Abort: cs_n high after 5 data bits of write → no reg_we, no txn_done, busy=0.
- rst_n low during DATA of burst write → all outputs reset; next frame cmd 0x81 data 0x7E writes addr 1 correctly.
